ram_fifo: RTL and testbench

RAM_FIFO -- requirements
Module: ram_fifo

---
 rtl/ram_fifo_pkg.sv | 19 +
 rtl/ram_fifo_ram1r1w.sv | 39 +++
 rtl/ram_fifo.sv | 135 +++++++++++++
 tb/tb_ram_fifo.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ram_fifo_pkg
// Brief   : Small shared definitions for the RAM-backed FIFO.
// Revision: 1.0 - initial release
// ============================================================================
package ram_fifo_pkg;

    // The output queue has two slots: a head register and a skid register.
    localparam int OQ_SLOTS = 2;

    // Number of occupied output-queue slots, widened so sums with the
    // in-flight flag cannot overflow.
    function automatic logic [2:0] oq_occ(input logic head_v, input logic skid_v);
        return {2'b00, head_v} + {2'b00, skid_v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_fifo_ram1r1w.sv
`default_nettype none
// ============================================================================
// Module  : ram1r1w
// Brief   : Simple dual-port RAM, one write port, one read port with a
//           one-cycle registered read. Contents are not reset.
// Revision: 1.0 - initial release
// ============================================================================
module ram1r1w #(
    parameter int WIDTH    = 32,
    parameter int LG_DEPTH = 4
) (
    input  logic                clk,
    input  logic                wr_en_i,
    input  logic [LG_DEPTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]    wr_data_i,
    input  logic                rd_en_i,
    input  logic [LG_DEPTH-1:0] rd_addr_i,
    output logic [WIDTH-1:0]    rd_data_o
);

    localparam int DEPTH = 1 << LG_DEPTH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write on request; registered read returns data the following cycle.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/ram_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ram_fifo
// Brief   : FIFO built on a 1R1W RAM with registered read, followed by a
//           two-entry output queue (head + skid) so a full-rate stream flows
//           without bubbles despite the RAM read latency.
// Revision: 1.0 - initial release
// ============================================================================
module ram_fifo
    import ram_fifo_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int LG_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [LG_DEPTH+1:0]   count,
    output logic                  empty
);

    localparam int                DEPTH   = 1 << LG_DEPTH;
    localparam logic [LG_DEPTH:0] C_DEPTH = (LG_DEPTH + 1)'(DEPTH);

    // Pointer / occupancy state
    logic [LG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LG_DEPTH:0]   ram_cnt_q, ram_cnt_d;
    logic                inflight_q, inflight_d;

    // Output queue state
    logic                head_v_q, head_v_d;
    logic [WIDTH-1:0]    head_data_q, head_data_d;
    logic                skid_v_q, skid_v_d;
    logic [WIDTH-1:0]    skid_data_q, skid_data_d;

    logic                w_push;
    logic                w_pop;
    logic                w_issue;
    logic [2:0]          w_occ;
    logic [WIDTH-1:0]    w_ram_rdata;

    assign in_ready  = (ram_cnt_q != C_DEPTH);
    assign out_valid = head_v_q;
    assign out_data  = head_data_q;
    assign count     = (LG_DEPTH + 2)'(ram_cnt_q) + (LG_DEPTH + 2)'(inflight_q)
                     + (LG_DEPTH + 2)'(w_occ);
    assign empty     = (count == '0);

    // Handshakes and read-issue decision. Reads are gated on the registered
    // RAM count, so a read can never target the slot being written this
    // cycle: rd_ptr == wr_ptr with ram_cnt != 0 only when full, and then no
    // push is accepted.
    always_comb begin
        w_push  = in_valid && in_ready;
        w_pop   = head_v_q && out_ready;
        w_occ   = oq_occ(head_v_q, skid_v_q);
        w_issue = (ram_cnt_q != '0) &&
                  ((w_occ + {2'b00, inflight_q}) < (3'(OQ_SLOTS) + {2'b00, w_pop}));
    end

    // Next-state for pointers, RAM occupancy and the output queue.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + LG_DEPTH'(w_push);
        rd_ptr_d    = rd_ptr_q + LG_DEPTH'(w_issue);
        ram_cnt_d   = ram_cnt_q + (LG_DEPTH + 1)'(w_push) - (LG_DEPTH + 1)'(w_issue);
        inflight_d  = w_issue;

        head_v_d    = head_v_q;
        head_data_d = head_data_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;

        // A pop shifts the skid entry into the head.
        if (w_pop) begin
            head_v_d    = skid_v_q;
            head_data_d = skid_data_q;
            skid_v_d    = 1'b0;
        end

        // Returning read data fills the first free slot.
        if (inflight_q) begin
            if (!head_v_d) begin
                head_v_d    = 1'b1;
                head_data_d = w_ram_rdata;
            end else begin
                skid_v_d    = 1'b1;
                skid_data_d = w_ram_rdata;
            end
        end
    end

    // State registers; reset discards everything, including a read in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            head_v_q    <= 1'b0;
            head_data_q <= '0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            inflight_q  <= inflight_d;
            head_v_q    <= head_v_d;
            head_data_q <= head_data_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
        end
    end

    ram1r1w #(
        .WIDTH    (WIDTH),
        .LG_DEPTH (LG_DEPTH)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (w_push),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (in_data),
        .rd_en_i   (w_issue),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (w_ram_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_fifo
// Brief   : Self-checking bench for ram_fifo (WIDTH=8, LG_DEPTH=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_ram_fifo;

    localparam int W  = 8;
    localparam int LG = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [LG+1:0] count;
    logic          empty;

    int n_cmp = 0;
    int n_err = 0;

    ram_fifo #(.WIDTH(W), .LG_DEPTH(LG)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          iv;
        logic [W-1:0]  d;
        logic          ordy;
        logic          e_ov;
        logic [W-1:0]  e_od;
        logic [LG+1:0] e_cnt;
        logic          e_ir;
        logic          e_emp;
    } vec_t;

    function automatic vec_t mkv(input logic iv, input logic [W-1:0] d, input logic ordy,
                                 input logic e_ov, input logic [W-1:0] e_od,
                                 input logic [LG+1:0] e_cnt, input logic e_ir,
                                 input logic e_emp);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt; v.e_ir = e_ir; v.e_emp = e_emp;
        return v;
    endfunction

    vec_t      vt [17];
    logic [7:0] expq [$];

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int        pushed, popped, first_ov, bubbles;
        logic      stalled_prev;
        logic [7:0] held;

        // Expected state after each clock edge (inputs applied before it).
        //           iv    data   ordy  | ov    od     cnt   ir    empty
        vt[0]  = mkv(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 4'd1, 1'b1, 1'b0);
        vt[1]  = mkv(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd1, 1'b1, 1'b0);
        vt[2]  = mkv(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 4'd1, 1'b1, 1'b0);
        vt[3]  = mkv(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b1);
        vt[4]  = mkv(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 4'd1, 1'b1, 1'b0);
        vt[5]  = mkv(1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 4'd2, 1'b1, 1'b0);
        vt[6]  = mkv(1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 4'd3, 1'b1, 1'b0);
        vt[7]  = mkv(1'b1, 8'h04, 1'b0, 1'b1, 8'h01, 4'd4, 1'b1, 1'b0);
        vt[8]  = mkv(1'b1, 8'h05, 1'b0, 1'b1, 8'h01, 4'd5, 1'b1, 1'b0);
        vt[9]  = mkv(1'b1, 8'h06, 1'b0, 1'b1, 8'h01, 4'd6, 1'b0, 1'b0);
        vt[10] = mkv(1'b1, 8'h07, 1'b0, 1'b1, 8'h01, 4'd6, 1'b0, 1'b0);
        vt[11] = mkv(1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 4'd5, 1'b1, 1'b0);
        vt[12] = mkv(1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 4'd4, 1'b1, 1'b0);
        vt[13] = mkv(1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 4'd3, 1'b1, 1'b0);
        vt[14] = mkv(1'b0, 8'h00, 1'b1, 1'b1, 8'h05, 4'd2, 1'b1, 1'b0);
        vt[15] = mkv(1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 4'd1, 1'b1, 1'b0);
        vt[16] = mkv(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b1);

        // ---------------- reset values ----------------
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_empty",     32'(empty),     32'd1);
        chk("rst_out_data",  32'(out_data),  32'd0);

        // Release mid-cycle; the very next edge accepts the first push.
        @(negedge clk);
        reset_n = 1'b1;

        // ---------------- single entry, fill and drain ----------------
        for (int i = 0; i < 17; i++) begin
            in_valid  = vt[i].iv;
            in_data   = vt[i].d;
            out_ready = vt[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
            chk($sformatf("vec%0d_count", i),     32'(count),     32'(vt[i].e_cnt));
            chk($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(vt[i].e_ir));
            chk($sformatf("vec%0d_empty", i),     32'(empty),     32'(vt[i].e_emp));
            if (vt[i].e_ov)
                chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vt[i].e_od));
        end

        // ---------------- streaming across pointer wrap ----------------
        pushed = 0; popped = 0; first_ov = -1; bubbles = 0;
        expq.delete();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && popped < 20; cyc++) begin
            in_valid = (pushed < 20);
            in_data  = 8'h10 + 8'(pushed);
            if (out_valid) begin
                if (first_ov < 0) first_ov = cyc;
                if (expq.size() == 0) chk("stream_unexpected_pop", 32'd1, 32'd0);
                else chk("stream_data", 32'(out_data), 32'(expq.pop_front()));
                popped++;
            end else if (first_ov >= 0) begin
                bubbles++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(in_data);
                pushed++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("stream_first_valid_cycle", 32'(first_ov), 32'd3);
        chk("stream_bubbles",           32'(bubbles),  32'd0);
        chk("stream_pushed",            32'(pushed),   32'd20);
        chk("stream_popped",            32'(popped),   32'd20);
        chk("stream_empty",             32'(empty),    32'd1);

        // ---------------- back-pressure ----------------
        pushed = 0;
        expq.delete();
        stalled_prev = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            in_valid  = (pushed < 24);
            in_data   = 8'h40 + 8'(pushed);
            out_ready = (cyc % 2 == 0);
            if (stalled_prev) begin
                chk("bp_hold_valid", 32'(out_valid), 32'd1);
                chk("bp_hold_data",  32'(out_data),  32'(held));
            end
            chk("bp_count_le6", 32'(count <= 4'd6), 32'd1);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) chk("bp_unexpected_pop", 32'd1, 32'd0);
                else chk("bp_data", 32'(out_data), 32'(expq.pop_front()));
            end
            stalled_prev = out_valid && !out_ready;
            held = out_data;
            if (in_valid && in_ready) begin
                expq.push_back(in_data);
                pushed++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (expq.size() == 0) break;
            if (out_valid) chk("bp_drain_data", 32'(out_data), 32'(expq.pop_front()));
            @(posedge clk);
            #1;
        end
        chk("bp_drain_left", 32'(expq.size()), 32'd0);
        chk("bp_empty",      32'(empty),       32'd1);
        chk("bp_no_extra",   32'(out_valid),   32'd0);

        // ---------------- reset mid-flight ----------------
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 8'h61 + 8'(k);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("mid_count_before_rst", 32'(count), 32'd3);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count",     32'(count),     32'd0);
        chk("mid_rst_empty",     32'(empty),     32'd1);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("post_rst_count", 32'(count), 32'd1);
        popped = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) begin
                if (popped == 0) chk("post_rst_first_data", 32'(out_data), 32'h5A);
                popped++;
            end
            @(posedge clk);
            #1;
        end
        chk("post_rst_pops",  32'(popped), 32'd1);
        chk("post_rst_empty", 32'(empty),  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
